// File: rtl/div_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | div_arb_pkg : shared types, constants and round-robin pick for the divider |
// |               sharing arbiter.                                             |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
package div_arb_pkg;

    localparam int         ARB_MAX_REQ = 8;
    localparam int         ARB_IDX_W   = 3;
    localparam int         CNT_W       = 3;
    localparam logic [7:0] RESP_ZERO_Q = 8'h00;

    typedef struct packed {
        logic                 vld;
        logic [ARB_IDX_W-1:0] id;
        logic                 zero;
        logic [7:0]           dividend;
    } tag_t;

    // Returns {found, index}. The search starts at ptr+1 and wraps, so the
    // entry nearest after ptr wins; the loop runs downward so it writes last.
    function automatic logic [ARB_IDX_W:0] rr_pick(
        input logic [ARB_MAX_REQ-1:0] elig,
        input logic [ARB_IDX_W-1:0]   ptr,
        input int                     nreq
    );
        logic [ARB_IDX_W:0] pick;
        int                 idx;
        pick = '0;
        for (int k = ARB_MAX_REQ; k >= 1; k--) begin
            if (k <= nreq) begin
                idx = (int'(ptr) + k) % nreq;
                if (elig[ARB_IDX_W'(idx)]) begin
                    pick = {1'b1, ARB_IDX_W'(idx)};
                end
            end
        end
        return pick;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rr_arbiter : round-robin arbiter with eligibility mask and one-hot grant.  |
// | Revision   : 1.0                                                           |
// +----------------------------------------------------------------------------+
module rr_arbiter
    import div_arb_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_i,
    input  logic [NREQ-1:0]      elig_i,
    output logic [NREQ-1:0]      grant_o,
    output logic                 grant_vld_o,
    output logic [ARB_IDX_W-1:0] grant_idx_o
);

    logic [ARB_IDX_W-1:0]   ptr_q;
    logic [ARB_IDX_W-1:0]   ptr_d;
    logic [ARB_MAX_REQ-1:0] w_mask;
    logic [ARB_IDX_W:0]     w_pick;

    always_comb begin
        w_mask             = '0;
        w_mask[NREQ-1:0]   = req_i & elig_i;
    end

    assign w_pick      = rr_pick(w_mask, ptr_q, NREQ);
    assign grant_vld_o = w_pick[ARB_IDX_W];
    assign grant_idx_o = w_pick[ARB_IDX_W-1:0];

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_grant
            assign grant_o[gi] = grant_vld_o && (grant_idx_o == ARB_IDX_W'(gi));
        end
    endgenerate

    always_comb begin
        ptr_d = ptr_q;
        if (grant_vld_o) begin
            ptr_d = grant_idx_o;
        end
    end

    // Pointer starts at the last requester so requester 0 wins first.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= ARB_IDX_W'(NREQ - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/div_share_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | div_share_arbiter : shares one pipelined 8-bit signed divider among NREQ   |
// |                     requesters; optional counters under DIV_ARB_PERF_EN.   |
// | Revision          : 1.0                                                    |
// +----------------------------------------------------------------------------+
module div_share_arbiter
    import div_arb_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int DIV_LAT = 11,
    parameter int MAX_OUT = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*8-1:0] req_dividend,
    input  logic [NREQ*8-1:0] req_divisor,
    output logic [NREQ-1:0]   req_ready,
    output logic              div_in_valid,
    output logic [7:0]        div_dividend,
    output logic [7:0]        div_divisor,
    input  logic [7:0]        div_quotient,
    input  logic [7:0]        div_remainder,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [7:0]        rsp_quotient,
    output logic [7:0]        rsp_remainder,
    output logic              rsp_err,
    output logic              busy
`ifdef DIV_ARB_PERF_EN
    ,
    input  logic [$clog2(NREQ):0] perf_sel,
    output logic [15:0]           perf_cnt
`endif
);

    localparam int               TAG_DEPTH = DIV_LAT + 1;
    localparam logic [CNT_W-1:0] C_MAX_OUT = CNT_W'(MAX_OUT);

    logic [NREQ-1:0]      w_elig;
    logic [NREQ-1:0]      w_grant;
    logic                 w_grant_vld;
    logic [ARB_IDX_W-1:0] w_grant_idx;
    logic [7:0]           w_sel_dividend;
    logic [7:0]           w_sel_divisor;

    logic [CNT_W-1:0]     out_cnt_q [NREQ];
    logic [CNT_W-1:0]     out_cnt_d [NREQ];

    logic                 div_in_valid_q;
    logic [7:0]           div_dividend_q;
    logic [7:0]           div_divisor_q;

    tag_t                 tag_q [TAG_DEPTH];
    tag_t                 tag_d;
    tag_t                 w_tag_out;
    logic                 w_tag_any;

    logic [NREQ-1:0]      rsp_valid_q;
    logic [NREQ-1:0]      rsp_valid_d;
    logic [7:0]           rsp_quot_q;
    logic [7:0]           rsp_quot_d;
    logic [7:0]           rsp_rem_q;
    logic [7:0]           rsp_rem_d;
    logic                 rsp_err_q;
    logic                 rsp_err_d;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_elig
            assign w_elig[gi] = out_cnt_q[gi] < C_MAX_OUT;
        end
    endgenerate

    rr_arbiter #(
        .NREQ        (NREQ)
    ) u_rr_arbiter (
        .clk         (clk),
        .rst         (rst),
        .req_i       (req_valid),
        .elig_i      (w_elig),
        .grant_o     (w_grant),
        .grant_vld_o (w_grant_vld),
        .grant_idx_o (w_grant_idx)
    );

    assign req_ready = w_grant;

    always_comb begin
        w_sel_dividend = '0;
        w_sel_divisor  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant[i]) begin
                w_sel_dividend = req_dividend[i*8 +: 8];
                w_sel_divisor  = req_divisor[i*8 +: 8];
            end
        end
        tag_d.vld      = w_grant_vld;
        tag_d.id       = w_grant_idx;
        tag_d.zero     = (w_sel_divisor == 8'h00);
        tag_d.dividend = w_sel_dividend;
    end

    // Zero divisors never reach the divider; their tag still flows so the
    // response keeps the same latency as a real division.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_in_valid_q <= 1'b0;
            div_dividend_q <= '0;
            div_divisor_q  <= '0;
        end else begin
            div_in_valid_q <= w_grant_vld && !tag_d.zero;
            if (w_grant_vld) begin
                div_dividend_q <= w_sel_dividend;
                div_divisor_q  <= w_sel_divisor;
            end
        end
    end

    assign div_in_valid = div_in_valid_q;
    assign div_dividend = div_dividend_q;
    assign div_divisor  = div_divisor_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < TAG_DEPTH; k++) begin
                tag_q[k] <= '0;
            end
        end else begin
            tag_q[0] <= tag_d;
            for (int k = 1; k < TAG_DEPTH; k++) begin
                tag_q[k] <= tag_q[k-1];
            end
        end
    end

    always_comb begin
        w_tag_any = 1'b0;
        for (int k = 0; k < TAG_DEPTH; k++) begin
            w_tag_any = w_tag_any | tag_q[k].vld;
        end
    end

    // Last tag stage lines up with the divider result of the same operation.
    always_comb begin
        w_tag_out   = tag_q[DIV_LAT];
        rsp_valid_d = '0;
        rsp_quot_d  = rsp_quot_q;
        rsp_rem_d   = rsp_rem_q;
        rsp_err_d   = rsp_err_q;
        for (int i = 0; i < NREQ; i++) begin
            rsp_valid_d[i] = w_tag_out.vld && (w_tag_out.id == ARB_IDX_W'(i));
        end
        if (w_tag_out.vld) begin
            if (w_tag_out.zero) begin
                rsp_quot_d = RESP_ZERO_Q;
                rsp_rem_d  = w_tag_out.dividend;
                rsp_err_d  = 1'b1;
            end else begin
                rsp_quot_d = div_quotient;
                rsp_rem_d  = div_remainder;
                rsp_err_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_q <= '0;
            rsp_quot_q  <= '0;
            rsp_rem_q   <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_quot_q  <= rsp_quot_d;
            rsp_rem_q   <= rsp_rem_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign rsp_valid     = rsp_valid_q;
    assign rsp_quotient  = rsp_quot_q;
    assign rsp_remainder = rsp_rem_q;
    assign rsp_err       = rsp_err_q;
    assign busy          = w_tag_any | (|rsp_valid_q);

    // A grant and a response for the same requester cancel out.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            out_cnt_d[i] = out_cnt_q[i];
            if (w_grant[i] && !rsp_valid_q[i]) begin
                out_cnt_d[i] = out_cnt_q[i] + CNT_W'(1);
            end else if (!w_grant[i] && rsp_valid_q[i]) begin
                out_cnt_d[i] = out_cnt_q[i] - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREQ; i++) begin
                out_cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                out_cnt_q[i] <= out_cnt_d[i];
            end
        end
    end

`ifdef DIV_ARB_PERF_EN
    localparam int PERF_SEL_W = $clog2(NREQ) + 1;

    logic [15:0] grant_cnt_q [NREQ];
    logic [15:0] zero_cnt_q;
    logic [15:0] perf_cnt_q;
    logic [15:0] perf_cnt_d;

    always_comb begin
        perf_cnt_d = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (perf_sel == PERF_SEL_W'(i)) begin
                perf_cnt_d = grant_cnt_q[i];
            end
        end
        if (perf_sel == PERF_SEL_W'(NREQ)) begin
            perf_cnt_d = zero_cnt_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREQ; i++) begin
                grant_cnt_q[i] <= '0;
            end
            zero_cnt_q <= '0;
            perf_cnt_q <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (w_grant[i] && (grant_cnt_q[i] != 16'hFFFF)) begin
                    grant_cnt_q[i] <= grant_cnt_q[i] + 16'd1;
                end
            end
            if (w_grant_vld && tag_d.zero && (zero_cnt_q != 16'hFFFF)) begin
                zero_cnt_q <= zero_cnt_q + 16'd1;
            end
            perf_cnt_q <= perf_cnt_d;
        end
    end

    assign perf_cnt = perf_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_div_share_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_div_share_arbiter : bench with a divider model and a reference model.   |
// | Revision             : 1.0                                                 |
// +----------------------------------------------------------------------------+
module tb_div_share_arbiter;

    localparam int NREQ    = 4;
    localparam int DIV_LAT = 11;
    localparam int MAX_OUT = 3;
    localparam int RLAT    = DIV_LAT + 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ*8-1:0] req_dividend = '0;
    logic [NREQ*8-1:0] req_divisor = '0;
    logic [NREQ-1:0]   req_ready;
    logic              div_in_valid;
    logic [7:0]        div_dividend;
    logic [7:0]        div_divisor;
    logic [7:0]        div_quotient;
    logic [7:0]        div_remainder;
    logic [NREQ-1:0]   rsp_valid;
    logic [7:0]        rsp_quotient;
    logic [7:0]        rsp_remainder;
    logic              rsp_err;
    logic              busy;
`ifdef DIV_ARB_PERF_EN
    logic [$clog2(NREQ):0] perf_sel = '0;
    logic [15:0]           perf_cnt;
    int                    m_pcnt [NREQ+1];
    int                    exp_perf = 0;
`endif

    div_share_arbiter #(
        .NREQ          (NREQ),
        .DIV_LAT       (DIV_LAT),
        .MAX_OUT       (MAX_OUT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_dividend  (req_dividend),
        .req_divisor   (req_divisor),
        .req_ready     (req_ready),
        .div_in_valid  (div_in_valid),
        .div_dividend  (div_dividend),
        .div_divisor   (div_divisor),
        .div_quotient  (div_quotient),
        .div_remainder (div_remainder),
        .rsp_valid     (rsp_valid),
        .rsp_quotient  (rsp_quotient),
        .rsp_remainder (rsp_remainder),
        .rsp_err       (rsp_err),
        .busy          (busy)
`ifdef DIV_ARB_PERF_EN
        ,
        .perf_sel      (perf_sel),
        .perf_cnt      (perf_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Signed 8-bit division, truncating toward zero: {quotient, remainder}.
    function automatic logic [15:0] sdiv(input logic [7:0] a, input logic [7:0] b);
        int sa;
        int sb;
        int q;
        int r;
        sa = $signed(a);
        sb = $signed(b);
        if (sb == 0) return 16'hA5A5;
        q = sa / sb;
        r = sa % sb;
        return {q[7:0], r[7:0]};
    endfunction

    // External divider: fixed latency, outputs junk in slots with no issue.
    logic [15:0] dpipe [DIV_LAT];
    always @(posedge clk) begin
        for (int k = DIV_LAT - 1; k >= 1; k--) dpipe[k] <= dpipe[k-1];
        dpipe[0] <= div_in_valid ? sdiv(div_dividend, div_divisor) : 16'($urandom);
    end
    assign div_quotient  = dpipe[DIV_LAT-1][15:8];
    assign div_remainder = dpipe[DIV_LAT-1][7:0];

    typedef struct {
        int         g;
        int         id;
        logic [7:0] dd;
        logic [7:0] ds;
    } ent_t;

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   m_ptr;
    int   m_cnt [NREQ];
    ent_t pend [$];
    logic [7:0] m_q, m_r;
    logic       m_err;

    logic [NREQ-1:0] obs_ready, obs_rsp;
    logic [7:0]      obs_q, obs_r, obs_dd, obs_ds;
    logic            obs_err, obs_busy, obs_div_v;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        pend.delete();
        m_ptr = NREQ - 1;
        for (int i = 0; i < NREQ; i++) m_cnt[i] = 0;
        m_q = 8'h00;
        m_r = 8'h00;
        m_err = 1'b0;
`ifdef DIV_ARB_PERF_EN
        for (int i = 0; i <= NREQ; i++) m_pcnt[i] = 0;
        exp_perf = 0;
`endif
    endtask

    function automatic logic [NREQ*8-1:0] opnd(input int slot, input logic [7:0] val);
        logic [NREQ*8-1:0] v;
        v = '0;
        v[slot*8 +: 8] = val;
        return v;
    endfunction

    // One clock cycle: apply inputs, compare every output, advance the model.
    task automatic step(input logic [NREQ-1:0] v, input logic [NREQ*8-1:0] dd,
                        input logic [NREQ*8-1:0] ds, input logic r);
        int              gid;
        int              rid;
        logic [NREQ-1:0] eg;
        logic [NREQ-1:0] er;
        logic [15:0]     res;
        req_valid    = v;
        req_dividend = dd;
        req_divisor  = ds;
        rst          = r;
`ifdef DIV_ARB_PERF_EN
        perf_sel = ($clog2(NREQ)+1)'($urandom_range(0, NREQ));
`endif
        #1;
        gid = -1;
        for (int k = 1; k <= NREQ; k++) begin
            int j;
            j = (m_ptr + k) % NREQ;
            if (gid < 0 && v[j] && m_cnt[j] < MAX_OUT) gid = j;
        end
        eg = '0;
        if (gid >= 0) eg[gid] = 1'b1;
        while (pend.size() > 0 && pend[0].g + RLAT < cyc) void'(pend.pop_front());
        er  = '0;
        rid = -1;
        if (pend.size() > 0 && pend[0].g + RLAT == cyc) begin
            rid = pend[0].id;
            er[rid] = 1'b1;
            if (pend[0].ds == 8'h00) begin
                m_q = 8'h00;
                m_r = pend[0].dd;
                m_err = 1'b1;
            end else begin
                res = sdiv(pend[0].dd, pend[0].ds);
                m_q = res[15:8];
                m_r = res[7:0];
                m_err = 1'b0;
            end
        end
        chk("req_ready", 32'(req_ready), 32'(eg));
        chk("rsp_valid", 32'(rsp_valid), 32'(er));
        chk("rsp_quotient", 32'(rsp_quotient), 32'(m_q));
        chk("rsp_remainder", 32'(rsp_remainder), 32'(m_r));
        chk("rsp_err", 32'(rsp_err), 32'(m_err));
        chk("busy", 32'(busy), 32'(pend.size() > 0));
        if (pend.size() > 0 && pend[$].g == cyc - 1 && pend[$].ds != 8'h00) begin
            chk("div_in_valid", 32'(div_in_valid), 32'd1);
            chk("div_dividend", 32'(div_dividend), 32'(pend[$].dd));
            chk("div_divisor", 32'(div_divisor), 32'(pend[$].ds));
        end else begin
            chk("div_in_valid", 32'(div_in_valid), 32'd0);
        end
`ifdef DIV_ARB_PERF_EN
        chk("perf_cnt", 32'(perf_cnt), 32'(exp_perf));
        exp_perf = m_pcnt[perf_sel] > 65535 ? 65535 : m_pcnt[perf_sel];
`endif
        obs_ready = req_ready;
        obs_rsp   = rsp_valid;
        obs_q     = rsp_quotient;
        obs_r     = rsp_remainder;
        obs_err   = rsp_err;
        obs_busy  = busy;
        obs_div_v = div_in_valid;
        obs_dd    = div_dividend;
        obs_ds    = div_divisor;
        if (r) begin
            model_reset();
        end else begin
            if (gid >= 0) begin
                m_ptr = gid;
                m_cnt[gid]++;
                pend.push_back('{g: cyc, id: gid, dd: dd[gid*8 +: 8], ds: ds[gid*8 +: 8]});
`ifdef DIV_ARB_PERF_EN
                m_pcnt[gid]++;
                if (ds[gid*8 +: 8] == 8'h00) m_pcnt[NREQ]++;
`endif
            end
            if (rid >= 0) m_cnt[rid]--;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step('0, '0, '0, 1'b0);
    endtask

    int              ng;
    logic [NREQ-1:0] rdy14;
    int              nrsp;
    logic [NREQ-1:0] rseq [32];
    logic [NREQ*8-1:0] t_dd, t_ds;

    initial begin
        model_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);

        // Reset state.
        step('0, '0, '0, 1'b0);
        chk("reset_rsp_valid", 32'(obs_rsp), 32'd0);
        chk("reset_busy", 32'(obs_busy), 32'd0);

        // 100 / 7 on requester 0.
        step(4'b0001, opnd(0, 8'd100), opnd(0, 8'd7), 1'b0);
        chk("t1_grant", 32'(obs_ready), 32'h1);
        step('0, '0, '0, 1'b0);
        chk("t1_issue", 32'(obs_div_v), 32'd1);
        chk("t1_issue_dd", 32'(obs_dd), 32'd100);
        idle(11);
        step('0, '0, '0, 1'b0);
        chk("t1_rsp_valid", 32'(obs_rsp), 32'h1);
        chk("t1_quot", 32'(obs_q), 32'd14);
        chk("t1_rem", 32'(obs_r), 32'd2);
        chk("t1_err", 32'(obs_err), 32'd0);

        // -50 / 0 on requester 2.
        step(4'b0100, opnd(2, 8'hCE), opnd(2, 8'h00), 1'b0);
        chk("t2_grant", 32'(obs_ready), 32'h4);
        step('0, '0, '0, 1'b0);
        chk("t2_no_issue", 32'(obs_div_v), 32'd0);
        idle(11);
        step('0, '0, '0, 1'b0);
        chk("t2_rsp_valid", 32'(obs_rsp), 32'h4);
        chk("t2_quot", 32'(obs_q), 32'h00);
        chk("t2_rem", 32'(obs_r), 32'hCE);
        chk("t2_err", 32'(obs_err), 32'd1);

        // Requester 1 alone, valid held: stalls at MAX_OUT.
        ng = 0;
        rdy14 = '0;
        for (int k = 0; k < 16; k++) begin
            step(4'b0010, opnd(1, 8'd9), opnd(1, 8'd4), 1'b0);
            if (k <= 13) ng += int'(obs_ready[1]);
            if (k == 14) rdy14 = obs_ready;
        end
        chk("t3_grants_before_rsp", 32'(ng), 32'd3);
        chk("t3_regrant", 32'(rdy14), 32'h2);

        // More in flight, then reset mid-operation.
        for (int k = 0; k < 3; k++) step('1, {8'd40, 8'd30, 8'd20, 8'd10}, {8'd3, 8'd5, 8'd7, 8'd9}, 1'b0);
        step('1, {8'd40, 8'd30, 8'd20, 8'd10}, {8'd3, 8'd5, 8'd7, 8'd9}, 1'b1);
        nrsp = 0;
        for (int k = 0; k < 20; k++) begin
            step('0, '0, '0, 1'b0);
            if (k == 0) chk("t5_busy_after_rst", 32'(obs_busy), 32'd0);
            nrsp += int'(obs_rsp != '0);
        end
        chk("t5_no_rsp_after_rst", 32'(nrsp), 32'd0);

        // All four valid: grants rotate 0,1,2,3 and return in order.
        for (int k = 0; k < 25; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                t_dd[i*8 +: 8] = 8'(10 * (i + 1) + k);
                t_ds[i*8 +: 8] = 8'(i + 2);
            end
            if (k < 8) step('1, t_dd, t_ds, 1'b0);
            else       step('0, '0, '0, 1'b0);
            rseq[k] = (k < 8) ? obs_ready : obs_rsp;
        end
        for (int k = 0; k < 8; k++) begin
            chk("t4_grant_order", 32'(rseq[k]), 32'(1 << (k % 4)));
            chk("t4_rsp_order", 32'(rseq[13 + k]), 32'(1 << (k % 4)));
        end

        // Randomized traffic with occasional resets.
        for (int n = 0; n < 3000; n++) begin
            logic [NREQ-1:0] v;
            logic            r;
            for (int i = 0; i < NREQ; i++) begin
                v[i] = ($urandom_range(0, 9) < 6);
                case ($urandom_range(0, 7))
                    0:       t_dd[i*8 +: 8] = 8'h80;
                    1:       t_dd[i*8 +: 8] = 8'h7F;
                    default: t_dd[i*8 +: 8] = 8'($urandom);
                endcase
                case ($urandom_range(0, 7))
                    0:       t_ds[i*8 +: 8] = 8'h00;
                    1:       t_ds[i*8 +: 8] = 8'hFF;
                    2:       t_ds[i*8 +: 8] = 8'h01;
                    default: t_ds[i*8 +: 8] = 8'($urandom);
                endcase
            end
            r = ($urandom_range(0, 399) == 0);
            step(v, t_dd, t_ds, r);
        end
        idle(20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
